decade_time_counter: RTL and testbench
======================================

Name: decade_time_counter

Overview:
- Upstream BCD source for the display path: a prescaled mm:ss time counter.
- Produces four registered BCD digits (sec ones/tens, min ones/tens). Each digit drives one bin_to_7seg instance per display digit.
- Supports run/stop, parallel load, and a minute-advance button pulse. A rollover pulse allows cascading to an hours stage.

Parameters:
- TICK_DIV, 50000000, system clocks per 1-second tick. Legal range is >= 2. Prescaler width is $clog2(TICK_DIV).

Ports:
- w_clk  input  1  system clock; all state on rising edge
- w_rst  input  1  synchronous, active-high reset
- w_run  input  1  1 = prescaler and counting enabled; 0 = hold
- w_load  input  1  1-cycle strobe: load time from w_load_min/w_load_sec
- w_load_min  input  8  BCD minutes {tens[7:4], ones[3:0]}
- w_load_sec  input  8  BCD seconds {tens[7:4], ones[3:0]}
- w_inc_min  input  1  1-cycle strobe (debounced upstream): minutes +1 mod 60
- w_sec_ones  output  4  BCD 0-9
- w_sec_tens  output  4  BCD 0-5
- w_min_ones  output  4  BCD 0-9
- w_min_tens  output  4  BCD 0-5
- w_tick  output  1  1-cycle pulse, high in the cycle digits show an advanced second
- w_wrap  output  1  1-cycle pulse, high in the cycle digits show 00:00 after 59:59
- w_load_err  output  1  1-cycle pulse, high the cycle after a load containing an invalid digit

Behaviour:
- Reset (w_rst=1 at edge): all digits 0, prescaler 0, w_tick=w_wrap=w_load_err=0. Reset overrides every other input.
- All outputs are registered. No combinational path from inputs to outputs.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while w_run=1, then wraps to 0.
  - Internal tick is asserted when the count equals TICK_DIV-1 and w_run=1.
  - With w_run=0, the prescaler holds its value and no tick occurs.
- Priority per cycle: w_rst > w_load > w_inc_min > tick.
- Tick (1 Hz) applies a BCD ripple in the same cycle:
  - sec_ones 9->0 carries to sec_tens.
  - sec_tens 5->0 carries to min_ones.
  - min_ones 9->0 carries to min_tens.
  - min_tens 5->0 asserts w_wrap.
  - Digits, w_tick and w_wrap update together at the next edge, giving 1-cycle latency from the internal tick.
- w_load:
  - Loads all four digits and clears the prescaler to 0.
  - Any ones digit > 9 or tens digit > 5 is replaced by 0. w_load_err then pulses in the same cycle the digits update.
  - No w_tick or w_wrap on a load cycle.
  - A tick coinciding with w_load is discarded.
- w_inc_min:
  - Minutes +1 (09->10, 59->00). Seconds unchanged, and w_wrap is not asserted.
  - Works regardless of w_run.
  - If the internal tick falls in the same cycle, the tick is deferred by exactly one cycle: the prescaler holds at TICK_DIV-1 and the tick fires on the next cycle if w_run is still 1.
- w_load and w_inc_min together: the load wins and the increment is dropped.
- Digits never hold non-BCD values. Digits are only written by reset, clamped load, or ripple logic.
- Reset mid-count: the next cycle shows 00:00 with the prescaler at 0. No pulse outputs.

Optional Feature:
- DECADE_COUNT_DOWN_EN: when defined, adds input w_dir (1 bit).
  - w_dir=1 counts down with BCD borrow: sec_ones 0->9, sec_tens 0->5, and so on. 00:00 -> 59:59 asserts w_wrap.
  - w_inc_min still increments minutes.
  - w_dir=0, or the macro undefined, gives up-count only and the port is absent.

Test Plan (TICK_DIV=4):
- Reset, then w_run=1 for 40 cycles -> w_tick every 4th cycle; digits 00:10 after the 10th tick; prescaler frozen while w_run=0.
- Load min=0x59, sec=0x58, run 8 cycles -> 59:59, then 00:00 with w_wrap=1 for exactly one cycle, coincident with w_tick.
- Load min=0x7A, sec=0x6C -> digits 00:00 (all four invalid digits cleared), w_load_err=1 for one cycle.
- At 09:30, pulse w_inc_min in the cycle the prescaler equals 3 -> 10:30 next cycle, then 10:31 one cycle later; no w_wrap.
- At 12:34 mid-count, assert w_rst for one cycle -> 00:00, no pulses; with w_load also high that cycle, reset wins.
- DECADE_COUNT_DOWN_EN, w_dir=1, load 00:01 -> ticks give 00:00, then 59:59 with w_wrap=1.

Source files
------------

// File: rtl/decade_time_counter_if.sv
// Control and BCD display bus between a time-counter controller and decade_time_counter.
// Optional macro DECADE_COUNT_DOWN_EN adds the w_dir count-direction signal.
interface decade_time_counter_if;
  logic       w_run;
  logic       w_load;
  logic [7:0] w_load_min;
  logic [7:0] w_load_sec;
  logic       w_inc_min;
`ifdef DECADE_COUNT_DOWN_EN
  logic       w_dir;
`endif
  logic [3:0] w_sec_ones;
  logic [3:0] w_sec_tens;
  logic [3:0] w_min_ones;
  logic [3:0] w_min_tens;
  logic       w_tick;
  logic       w_wrap;
  logic       w_load_err;

  modport master (
    output w_run, w_load, w_load_min, w_load_sec, w_inc_min,
`ifdef DECADE_COUNT_DOWN_EN
    output w_dir,
`endif
    input  w_sec_ones, w_sec_tens, w_min_ones, w_min_tens,
    input  w_tick, w_wrap, w_load_err
  );

  modport slave (
    input  w_run, w_load, w_load_min, w_load_sec, w_inc_min,
`ifdef DECADE_COUNT_DOWN_EN
    input  w_dir,
`endif
    output w_sec_ones, w_sec_tens, w_min_ones, w_min_tens,
    output w_tick, w_wrap, w_load_err
  );
endinterface

// File: rtl/decade_time_counter.sv
// Prescaled mm:ss BCD time counter with run/stop, clamped parallel load and minute advance.
// Optional macro DECADE_COUNT_DOWN_EN enables BCD count-down selected by w_dir.
module decade_time_counter #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input logic                  w_clk,
  input logic                  w_rst,
  decade_time_counter_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [3:0]    sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
  logic          tick_q, wrap_q, load_err_q;

  logic          count_down;
  logic          tick_int;
  logic [PW-1:0] presc_adv;
  logic [3:0]    r_so, r_st, r_mo, r_mt;
  logic          r_wrap;
  logic [3:0]    i_mo, i_mt;
  logic [3:0]    ld_so, ld_st, ld_mo, ld_mt;
  logic          ld_err;

`ifdef DECADE_COUNT_DOWN_EN
  assign count_down = bus.w_dir;
`else
  assign count_down = 1'b0;
`endif

  assign tick_int  = bus.w_run && (presc_q == PRESC_MAX);
  assign presc_adv = !bus.w_run ? presc_q :
                     (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);

  // One-second BCD ripple, up or down, with wrap flag at the hour boundary
  always_comb begin
    r_so   = sec_ones_q;
    r_st   = sec_tens_q;
    r_mo   = min_ones_q;
    r_mt   = min_tens_q;
    r_wrap = 1'b0;
    if (!count_down) begin
      if (sec_ones_q != 4'd9) r_so = sec_ones_q + 4'd1;
      else begin
        r_so = 4'd0;
        if (sec_tens_q != 4'd5) r_st = sec_tens_q + 4'd1;
        else begin
          r_st = 4'd0;
          if (min_ones_q != 4'd9) r_mo = min_ones_q + 4'd1;
          else begin
            r_mo = 4'd0;
            if (min_tens_q != 4'd5) r_mt = min_tens_q + 4'd1;
            else begin
              r_mt   = 4'd0;
              r_wrap = 1'b1;
            end
          end
        end
      end
    end else begin
      if (sec_ones_q != 4'd0) r_so = sec_ones_q - 4'd1;
      else begin
        r_so = 4'd9;
        if (sec_tens_q != 4'd0) r_st = sec_tens_q - 4'd1;
        else begin
          r_st = 4'd5;
          if (min_ones_q != 4'd0) r_mo = min_ones_q - 4'd1;
          else begin
            r_mo = 4'd9;
            if (min_tens_q != 4'd0) r_mt = min_tens_q - 4'd1;
            else begin
              r_mt   = 4'd5;
              r_wrap = 1'b1;
            end
          end
        end
      end
    end
  end

  // Minute advance, mod 60, never flags a wrap
  always_comb begin
    i_mo = min_ones_q + 4'd1;
    i_mt = min_tens_q;
    if (min_ones_q == 4'd9) begin
      i_mo = 4'd0;
      i_mt = (min_tens_q == 4'd5) ? 4'd0 : min_tens_q + 4'd1;
    end
  end

  // Out-of-range load digits are forced to zero and reported
  assign ld_so  = (bus.w_load_sec[3:0] > 4'd9) ? 4'd0 : bus.w_load_sec[3:0];
  assign ld_st  = (bus.w_load_sec[7:4] > 4'd5) ? 4'd0 : bus.w_load_sec[7:4];
  assign ld_mo  = (bus.w_load_min[3:0] > 4'd9) ? 4'd0 : bus.w_load_min[3:0];
  assign ld_mt  = (bus.w_load_min[7:4] > 4'd5) ? 4'd0 : bus.w_load_min[7:4];
  assign ld_err = (bus.w_load_sec[3:0] > 4'd9) || (bus.w_load_sec[7:4] > 4'd5) ||
                  (bus.w_load_min[3:0] > 4'd9) || (bus.w_load_min[7:4] > 4'd5);

  // Priority: reset > load > minute advance > tick
  always_ff @(posedge w_clk) begin
    tick_q     <= 1'b0;
    wrap_q     <= 1'b0;
    load_err_q <= 1'b0;
    if (w_rst) begin
      presc_q    <= '0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
    end else if (bus.w_load) begin
      presc_q    <= '0;
      sec_ones_q <= ld_so;
      sec_tens_q <= ld_st;
      min_ones_q <= ld_mo;
      min_tens_q <= ld_mt;
      load_err_q <= ld_err;
    end else if (bus.w_inc_min) begin
      // A coincident tick is deferred: hold the prescaler at its terminal count
      presc_q    <= tick_int ? presc_q : presc_adv;
      min_ones_q <= i_mo;
      min_tens_q <= i_mt;
    end else if (tick_int) begin
      presc_q    <= '0;
      sec_ones_q <= r_so;
      sec_tens_q <= r_st;
      min_ones_q <= r_mo;
      min_tens_q <= r_mt;
      tick_q     <= 1'b1;
      wrap_q     <= r_wrap;
    end else begin
      presc_q    <= presc_adv;
    end
  end

  assign bus.w_sec_ones = sec_ones_q;
  assign bus.w_sec_tens = sec_tens_q;
  assign bus.w_min_ones = min_ones_q;
  assign bus.w_min_tens = min_tens_q;
  assign bus.w_tick     = tick_q;
  assign bus.w_wrap     = wrap_q;
  assign bus.w_load_err = load_err_q;

endmodule

// File: tb/tb_decade_time_counter.sv
// Scoreboard bench for decade_time_counter: a seconds-of-hour reference model predicts
// every cycle's outputs; a monitor compares them after each rising edge.
module tb_decade_time_counter;

  localparam int TD = 4;
`ifdef DECADE_COUNT_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  decade_time_counter_if bus ();

  decade_time_counter #(.TICK_DIV(TD)) dut (
    .w_clk (clk),
    .w_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference state: elapsed seconds within the hour, and prescaler count
  int m_t = 0;
  int m_p = 0;

  logic [18:0] sb [$];

  function automatic int bcd_val(input logic [7:0] v, output bit bad);
    int tens;
    int ones;
    tens = int'(v[7:4]);
    ones = int'(v[3:0]);
    bad  = 1'b0;
    if (ones > 9) begin ones = 0; bad = 1'b1; end
    if (tens > 5) begin tens = 0; bad = 1'b1; end
    return tens * 10 + ones;
  endfunction

  task automatic step(input bit run = 1'b1, input bit rst_i = 1'b0, input bit ld = 1'b0,
                      input logic [7:0] lmin = 8'h00, input logic [7:0] lsec = 8'h00,
                      input bit inc = 1'b0, input bit dir = 1'b0);
    bit tick_now, e_tick, e_wrap, e_err, b1, b2, down;
    int mins, secs, m, s;
    @(negedge clk);
    rst            = rst_i;
    bus.w_run      = run;
    bus.w_load     = ld;
    bus.w_load_min = lmin;
    bus.w_load_sec = lsec;
    bus.w_inc_min  = inc;
`ifdef DECADE_COUNT_DOWN_EN
    bus.w_dir      = dir;
`endif
    down     = dir && DOWN_EN;
    tick_now = run && (m_p == TD - 1);
    e_tick = 1'b0; e_wrap = 1'b0; e_err = 1'b0;
    if (rst_i) begin
      m_t = 0; m_p = 0;
    end else if (ld) begin
      m = bcd_val(lmin, b1);
      s = bcd_val(lsec, b2);
      m_t = m * 60 + s; m_p = 0; e_err = b1 | b2;
    end else if (inc) begin
      m_t = (((m_t / 60) + 1) % 60) * 60 + (m_t % 60);
      if (!tick_now && run) m_p = (m_p + 1) % TD;
    end else if (tick_now) begin
      e_tick = 1'b1;
      if (down) begin e_wrap = (m_t == 0);    m_t = (m_t + 3599) % 3600; end
      else      begin e_wrap = (m_t == 3599); m_t = (m_t + 1) % 3600;    end
      m_p = 0;
    end else if (run) begin
      m_p = (m_p + 1) % TD;
    end
    mins = m_t / 60;
    secs = m_t % 60;
    sb.push_back({4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                  e_tick, e_wrap, e_err});
  endtask

  // Monitor: every cycle the DUT presents a full output word
  logic [18:0] exp_w, got_w;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb.size() > 0) begin
      exp_w = sb.pop_front();
      got_w = {bus.w_min_tens, bus.w_min_ones, bus.w_sec_tens, bus.w_sec_ones,
               bus.w_tick, bus.w_wrap, bus.w_load_err};
      checks++;
      if (got_w !== exp_w) begin
        failures++;
        $display("FAIL outputs cyc=%0d got mm:ss=%h%h:%h%h t/w/e=%b%b%b exp mm:ss=%h%h:%h%h t/w/e=%b%b%b",
                 cyc, got_w[18:15], got_w[14:11], got_w[10:7], got_w[6:3], got_w[2], got_w[1], got_w[0],
                 exp_w[18:15], exp_w[14:11], exp_w[10:7], exp_w[6:3], exp_w[2], exp_w[1], exp_w[0]);
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    bus.w_run = 1'b0; bus.w_load = 1'b0; bus.w_load_min = 8'h00;
    bus.w_load_sec = 8'h00; bus.w_inc_min = 1'b0;
`ifdef DECADE_COUNT_DOWN_EN
    bus.w_dir = 1'b0;
`endif
    step(1'b0, 1'b1);
    // Free run to 00:10, then hold, then resume
    repeat (40) step();
    repeat (5) step(1'b0);
    repeat (4) step();
    // Hour wrap
    step(1'b1, 1'b0, 1'b1, 8'h59, 8'h58);
    repeat (8) step();
    // Invalid load digits
    step(1'b0, 1'b0, 1'b1, 8'h7A, 8'h6C);
    step(1'b0);
    // Minute advance colliding with a tick
    step(1'b1, 1'b0, 1'b1, 8'h09, 8'h30);
    guard = 0;
    while (m_p != TD - 1 && guard < 10) begin step(); guard++; end
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    repeat (3) step();
    // Minute advance at 59 with run stopped
    step(1'b0, 1'b0, 1'b1, 8'h59, 8'h07);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    // Load and advance together: load wins
    step(1'b1, 1'b0, 1'b1, 8'h22, 8'h11, 1'b1);
    // Reset mid-count, with load also asserted
    step(1'b1, 1'b0, 1'b1, 8'h12, 8'h34);
    repeat (6) step();
    step(1'b1, 1'b1, 1'b1, 8'h45, 8'h45);
    repeat (3) step();
`ifdef DECADE_COUNT_DOWN_EN
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1);
    repeat (12) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
`endif
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] rm, rs;
      rm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'({4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))});
      rs = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'({4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))});
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 127) == 0),
           ($urandom_range(0, 31) == 0), rm, rs,
           ($urandom_range(0, 15) == 0), 1'($urandom));
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
